// File: rtl/aplic_msi_dispatcher.sv
// aplic_msi_dispatcher: MSI-mode delivery sequencer for an APLIC domain.
// Scans the pending/enabled vectors in SCAN_W-wide windows (round-robin).
// It selects the lowest eligible source in the current window and issues one
// MSI write (hart, EIID) over a valid/ready handshake. It then pulses a
// pending-clear for that source back to the register bank.
//
// Ports:
//   i_clk, i_rst             clock, asynchronous active-high reset
//   i_msi_mode, i_domain_ie  domaincfg.DM == MSI and domaincfg.IE
//   i_pending, i_enabled     per-source pending / enable bits
//   i_target_hart/_eiid      per-source target fields, flat (source k at k*W +: W)
//   o_msi_valid/i_msi_ready  MSI write request handshake
//   o_msi_hart/_eiid/_src    request payload, stable while o_msi_valid is high
//   o_clr_valid, o_clr_src   one-cycle pending-clear pulse and its source
//   o_busy                   high while a selected source is being serviced
module aplic_msi_dispatcher #(
  parameter int unsigned NR_SRC   = 256,
  parameter int unsigned NR_HARTS = 5,
  parameter int unsigned SCAN_W   = 32,
  parameter int unsigned SRC_W    = $clog2(NR_SRC),
  parameter int unsigned HART_W   = 14,
  parameter int unsigned EIID_W   = 11
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_msi_mode,
  input  logic                       i_domain_ie,
  input  logic [NR_SRC-1:0]          i_pending,
  input  logic [NR_SRC-1:0]          i_enabled,
  input  logic [NR_SRC*HART_W-1:0]   i_target_hart,
  input  logic [NR_SRC*EIID_W-1:0]   i_target_eiid,
  output logic                       o_msi_valid,
  input  logic                       i_msi_ready,
  output logic [HART_W-1:0]          o_msi_hart,
  output logic [EIID_W-1:0]          o_msi_eiid,
  output logic [SRC_W-1:0]           o_msi_src,
  output logic                       o_clr_valid,
  output logic [SRC_W-1:0]           o_clr_src,
  output logic                       o_busy
);

  localparam int unsigned NR_WIN = NR_SRC / SCAN_W;
  localparam int unsigned WIN_W  = (NR_WIN > 1) ? $clog2(NR_WIN) : 1;

  typedef enum logic [1:0] {
    ST_SCAN  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  state_e              state_q;
  logic [WIN_W-1:0]    win_q;
  logic [WIN_W-1:0]    win_next_c;
  logic [SRC_W-1:0]    src_q;
  logic [HART_W-1:0]   hart_q;
  logic [EIID_W-1:0]   eiid_q;
  logic                msi_valid_q;
  logic                clr_valid_q;
  logic                busy_q;

  logic                hit_c;
  logic [SRC_W-1:0]    hit_src_c;
  logic [HART_W-1:0]   hit_hart_c;
  logic [EIID_W-1:0]   hit_eiid_c;
  int unsigned         base_c;
  logic [SRC_W-1:0]    idx_c;

  // Round-robin window pointer with wrap.
  always_comb begin
    win_next_c = win_q + 1'b1;
    if (win_q == WIN_W'(NR_WIN - 1)) begin
      win_next_c = '0;
    end
  end

  // Lowest-index eligible source in the current window; source 0 is reserved.
  always_comb begin
    hit_c     = 1'b0;
    hit_src_c = '0;
    idx_c     = '0;
    base_c    = 32'(win_q) * SCAN_W;
    for (int unsigned j = 0; j < SCAN_W; j++) begin
      idx_c = SRC_W'(base_c + j);
      if (!hit_c && (idx_c != '0) && i_pending[idx_c] && i_enabled[idx_c]
          && i_msi_mode && i_domain_ie) begin
        hit_c     = 1'b1;
        hit_src_c = idx_c;
      end
    end
    hit_hart_c = i_target_hart[32'(hit_src_c) * HART_W +: HART_W];
    hit_eiid_c = i_target_eiid[32'(hit_src_c) * EIID_W +: EIID_W];
  end

  // Dispatch sequencer. A request, once raised, is held until accepted
  // regardless of later changes to IE, mode, pending or enable.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_SCAN;
      win_q       <= '0;
      src_q       <= '0;
      hart_q      <= '0;
      eiid_q      <= '0;
      msi_valid_q <= 1'b0;
      clr_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_SCAN: begin
          if (hit_c) begin
            src_q  <= hit_src_c;
            hart_q <= hit_hart_c;
            eiid_q <= hit_eiid_c;
            busy_q <= 1'b1;
            // Out-of-range target: drop the interrupt, clear without writing.
            if (32'(hit_hart_c) < NR_HARTS) begin
              state_q     <= ST_ISSUE;
              msi_valid_q <= 1'b1;
            end else begin
              state_q     <= ST_CLEAR;
              clr_valid_q <= 1'b1;
            end
          end else begin
            win_q <= win_next_c;
          end
        end
        ST_ISSUE: begin
          if (i_msi_ready) begin
            state_q     <= ST_CLEAR;
            msi_valid_q <= 1'b0;
            clr_valid_q <= 1'b1;
          end
        end
        ST_CLEAR: begin
          // Advance past the serviced window so other windows get a turn.
          state_q     <= ST_SCAN;
          clr_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          win_q       <= win_next_c;
        end
        default: begin
          state_q     <= ST_SCAN;
          msi_valid_q <= 1'b0;
          clr_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign o_msi_valid = msi_valid_q;
  assign o_msi_hart  = hart_q;
  assign o_msi_eiid  = eiid_q;
  assign o_msi_src   = src_q;
  assign o_clr_valid = clr_valid_q;
  assign o_clr_src   = src_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_aplic_msi_dispatcher.sv
// Self-checking bench for aplic_msi_dispatcher: directed scenarios plus a
// randomized phase, all checked cycle by cycle against a behavioural model.
// The bench also plays the APLIC register bank and clears pending bits when
// the model says a clear is due.
module tb_aplic_msi_dispatcher;

  localparam int NR_SRC   = 256;
  localparam int NR_HARTS = 5;
  localparam int SCAN_W   = 32;
  localparam int SRC_W    = 8;
  localparam int HART_W   = 14;
  localparam int EIID_W   = 11;
  localparam int NWIN     = NR_SRC / SCAN_W;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      mode = 1'b0;
  logic                      ie = 1'b0;
  logic [NR_SRC-1:0]         pend = '0;
  logic [NR_SRC-1:0]         en = '0;
  logic [NR_SRC*HART_W-1:0]  tgt_hart = '0;
  logic [NR_SRC*EIID_W-1:0]  tgt_eiid = '0;
  logic                      msi_valid;
  logic                      msi_ready = 1'b0;
  logic [HART_W-1:0]         msi_hart;
  logic [EIID_W-1:0]         msi_eiid;
  logic [SRC_W-1:0]          msi_src;
  logic                      clr_valid;
  logic [SRC_W-1:0]          clr_src;
  logic                      busy;

  aplic_msi_dispatcher dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_msi_mode    (mode),
    .i_domain_ie   (ie),
    .i_pending     (pend),
    .i_enabled     (en),
    .i_target_hart (tgt_hart),
    .i_target_eiid (tgt_eiid),
    .o_msi_valid   (msi_valid),
    .i_msi_ready   (msi_ready),
    .o_msi_hart    (msi_hart),
    .o_msi_eiid    (msi_eiid),
    .o_msi_src     (msi_src),
    .o_clr_valid   (clr_valid),
    .o_clr_src     (clr_src),
    .o_busy        (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: window pointer, an outstanding request, a clear due this cycle.
  int m_win;
  bit m_req;
  bit m_clr;
  int m_src, m_hart, m_eiid;
  int m_n_msi;

  int dut_q[$];
  int clr_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_target(input int k, input int h, input int e);
    tgt_hart[k*HART_W +: HART_W] = HART_W'(h);
    tgt_eiid[k*EIID_W +: EIID_W] = EIID_W'(e);
  endtask

  task automatic model_reset();
    m_win = 0; m_req = 0; m_clr = 0;
    m_src = 0; m_hart = 0; m_eiid = 0;
  endtask

  // One clock of the model, using the inputs the DUT saw before the edge.
  task automatic model_advance();
    bit found;
    found = 0;
    if (m_clr) begin
      m_clr = 0;
      m_win = (m_win + 1) % NWIN;
    end else if (m_req) begin
      if (msi_ready) begin
        m_req = 0;
        m_clr = 1;
        m_n_msi++;
      end
    end else begin
      for (int k = m_win * SCAN_W; k < (m_win + 1) * SCAN_W; k++) begin
        if (!found && k != 0 && pend[k] && en[k] && mode && ie) begin
          found  = 1;
          m_src  = k;
          m_hart = int'(tgt_hart[k*HART_W +: HART_W]);
          m_eiid = int'(tgt_eiid[k*EIID_W +: EIID_W]);
        end
      end
      if (!found) m_win = (m_win + 1) % NWIN;
      else if (m_hart < NR_HARTS) m_req = 1;
      else m_clr = 1;
    end
  endtask

  task automatic step();
    if (msi_valid && msi_ready) dut_q.push_back(int'(msi_src));
    @(posedge clk);
    #1;
    model_advance();
    chk("msi_valid", 32'(msi_valid), 32'(m_req));
    chk("clr_valid", 32'(clr_valid), 32'(m_clr));
    chk("busy", 32'(busy), 32'(m_req | m_clr));
    if (m_req) begin
      chk("msi_hart", 32'(msi_hart), 32'(m_hart));
      chk("msi_eiid", 32'(msi_eiid), 32'(m_eiid));
      chk("msi_src", 32'(msi_src), 32'(m_src));
    end
    if (m_clr) begin
      chk("clr_src", 32'(clr_src), 32'(m_src));
      pend[m_src] = 1'b0;
    end
    if (clr_valid) clr_q.push_back(int'(clr_src));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Assert reset mid-cycle; outputs must drop without waiting for a clock.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    chk({tag, "_valid"}, 32'(msi_valid), 32'd0);
    chk({tag, "_clr"}, 32'(clr_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_pay"}, 32'({msi_hart, msi_eiid, msi_src}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    dut_q.delete();
    clr_q.delete();
  endtask

  task automatic clean_env();
    pend = '0; en = '0; tgt_hart = '0; tgt_eiid = '0;
    mode = 1'b1; ie = 1'b1; msi_ready = 1'b1;
  endtask

  function automatic logic [31:0] q_at(input int q[$], input int i);
    if (i < q.size()) return 32'(q[i]);
    return 32'hFFFF_FFFF;
  endfunction

  initial begin
    int exp3[3];
    int k;
    m_n_msi = 0;
    model_reset();
    do_reset("rst0");

    // Single source, window 0.
    clean_env();
    set_target(5, 2, 17);
    pend[5] = 1'b1; en[5] = 1'b1;
    run(12);
    chk("t1_nmsi", 32'(dut_q.size()), 32'd1);
    chk("t1_src", q_at(dut_q, 0), 32'd5);
    chk("t1_clr", q_at(clr_q, 0), 32'd5);

    // Three sources in three windows, dispatched in window order.
    do_reset("rst1");
    clean_env();
    set_target(3, 0, 3); set_target(40, 1, 40); set_target(200, 4, 200);
    pend[3] = 1; pend[40] = 1; pend[200] = 1;
    en[3] = 1; en[40] = 1; en[200] = 1;
    run(30);
    exp3 = '{3, 40, 200};
    chk("t2_nmsi", 32'(dut_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("t2_order", q_at(dut_q, i), 32'(exp3[i]));
      chk("t2_clr", q_at(clr_q, i), 32'(exp3[i]));
    end

    // Backpressure, then IE dropped while the request is committed.
    do_reset("rst2");
    clean_env();
    set_target(7, 3, 1234);
    pend[7] = 1; en[7] = 1; msi_ready = 1'b0;
    run(11);
    ie = 1'b0;
    step();
    chk("t3_held", 32'(msi_valid), 32'd1);
    msi_ready = 1'b1;
    run(4);
    chk("t3_nmsi", 32'(dut_q.size()), 32'd1);
    chk("t3_src", q_at(dut_q, 0), 32'd7);
    chk("t3_clr", q_at(clr_q, 0), 32'd7);

    // Invalid target hart: clear only, no write.
    do_reset("rst3");
    clean_env();
    set_target(9, 6, 5);
    pend[9] = 1; en[9] = 1;
    run(6);
    chk("t4_nmsi", 32'(dut_q.size()), 32'd0);
    chk("t4_nclr", 32'(clr_q.size()), 32'd1);
    chk("t4_clr", q_at(clr_q, 0), 32'd9);

    // Ineligible: reserved source 0, disabled source, non-MSI mode.
    do_reset("rst4");
    clean_env();
    pend[0] = 1; en[0] = 1; pend[12] = 1;
    run(20);
    en[12] = 1; mode = 1'b0;
    run(20);
    chk("t5_nmsi", 32'(dut_q.size()), 32'd0);
    chk("t5_nclr", 32'(clr_q.size()), 32'd0);
    mode = 1'b1;

    // Reset while waiting on ready; source is re-dispatched afterwards.
    do_reset("rst5");
    clean_env();
    set_target(33, 1, 99);
    pend[33] = 1; en[33] = 1; msi_ready = 1'b0;
    k = 0;
    while (!msi_valid && k < 20) begin step(); k++; end
    chk("t6_valid", 32'(msi_valid), 32'd1);
    run(3);
    do_reset("t6_rst");
    chk("t6_pend", 32'(pend[33]), 32'd1);
    msi_ready = 1'b1;
    run(20);
    chk("t6_nmsi", 32'(dut_q.size()), 32'd1);
    chk("t6_src", q_at(dut_q, 0), 32'd33);

    // Randomized traffic against the model.
    do_reset("rst6");
    clean_env();
    m_n_msi = 0;
    for (int s = 0; s < NR_SRC; s++) begin
      set_target(s, int'($urandom_range(0, 6)), int'($urandom_range(0, 2047)));
      en[s] = 1'($urandom_range(0, 3) != 0);
    end
    for (int c = 0; c < 2000; c++) begin
      msi_ready = 1'($urandom_range(0, 3) != 0);
      ie        = 1'($urandom_range(0, 15) != 0);
      mode      = 1'($urandom_range(0, 31) != 0);
      if ($urandom_range(0, 3) == 0) begin
        k = int'($urandom_range(0, NR_SRC - 1));
        if (!(m_clr && k == m_src)) pend[k] = 1'b1;
      end
      if ($urandom_range(0, 15) == 0) begin
        k = int'($urandom_range(0, NR_SRC - 1));
        en[k] = ~en[k];
      end
      step();
    end
    chk("rnd_nmsi", 32'(dut_q.size()), 32'(m_n_msi));
    chk("rnd_any", 32'(m_n_msi > 20), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
